regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   XLEN_DEF  - default register data width
//   NREGS_DEF - default register count (power of two, >= 2)
//   addr_width() - derives the register index width from a register count
//   reg_idx_t - register index type for the default configuration
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per architectural register.
//   An accepted issue marks its destination busy; a writeback clears the
//   busy bit of the written register. Register 0 is never busy.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   issue_valid/issue_rd - destination claim from the issue stage
//   wr_en/wr_addr        - writeback ports (NWR of them, packed)
//   busy                 - current busy vector (registered state)
//   issue_stall          - combinational: claimed destination still busy
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NWR   = 2,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy,
  output logic              issue_stall
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             issue_take;

  assign issue_stall = busy_q[issue_rd] & issue_valid & (issue_rd != '0);
  assign issue_take  = issue_valid & ~issue_stall & (issue_rd != '0);

  // Clears are applied before the set so that a new producer claiming a
  // register in the same cycle as its old writeback keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (issue_take) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with an issue scoreboard.
//   NRD registered read ports (latency 1) return data and the busy bit of
//   the addressed register; NWR write ports, highest index wins on a
//   collision; register 0 reads as zero and ignores writes.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   rd_addr/rd_data/rd_busy - packed read ports, port p at slice p
//   wr_en/wr_addr/wr_data - packed writeback ports
//   issue_valid/issue_rd  - destination claim; issue_stall when still busy
// Build option:
//   REGFILE_BYPASS_EN - a read that hits a same-edge write returns the
//   written data and busy=0 instead of the pre-write contents.
import regfile_pkg::*;

module regfile_mp #(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_stall
);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic [XLEN-1:0]     rd_val_p0 [NRD];
  logic [NRD-1:0]      rd_bsy_p0;
  logic [NRD*XLEN-1:0] rd_data_p1;
  logic [NRD-1:0]      rd_busy_p1;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .issue_stall (issue_stall)
  );

  // Register array: later ports in the loop overwrite earlier ones, so the
  // highest-indexed port wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // ---- stage p0: address lookup (regs[0] is never written, so reads 0) ----
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_val_p0[p] = regs[rd_addr[p*AW +: AW]];
      rd_bsy_p0[p] = busy[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW]) &&
            (rd_addr[p*AW +: AW] != '0)) begin
          rd_val_p0[p] = wr_data[w*XLEN +: XLEN];
          rd_bsy_p0[p] = 1'b0;
        end
      end
`endif
    end
  end

  // ---- stage p1: registered read outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
      rd_busy_p1 <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) rd_data_p1[p*XLEN +: XLEN] <= rd_val_p0[p];
      rd_busy_p1 <= rd_bsy_p0;
    end
  end

  assign rd_data = rd_data_p1;
  assign rd_busy = rd_busy_p1;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default parameters).
// A behavioural model (plain arrays of register values and busy flags)
// predicts read data, read busy and issue_stall for every clock.
import regfile_pkg::*;

module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_stall;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_regs [32];
  bit              m_busy [32];
  logic [XLEN-1:0] exp_data [NRD];
  bit              exp_busy [NRD];

  regfile_mp dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    reset = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic set_rd(input int p, input reg_idx_t a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int w, input reg_idx_t a, input logic [XLEN-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  function automatic bit model_stall();
    return issue_valid && (issue_rd != 0) && m_busy[issue_rd];
  endfunction

  // Advance one clock: predict the registered read outputs from the
  // pre-edge state, apply writes/issue to the model, then step the DUT.
  task automatic tick();
    bit stall;
    stall = model_stall();
    if (reset) begin
      for (int p = 0; p < NRD; p++) begin exp_data[p] = '0; exp_busy[p] = 1'b0; end
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      for (int p = 0; p < NRD; p++) begin
        int a;
        a = rd_addr[p*AW +: AW];
        exp_data[p] = (a == 0) ? '0 : m_regs[a];
        exp_busy[p] = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++)
          if (wr_en[w] && a != 0 && int'(wr_addr[w*AW +: AW]) == a) begin
            exp_data[p] = wr_data[w*XLEN +: XLEN];
            exp_busy[p] = 1'b0;
          end
`endif
      end
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
          m_regs[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
          m_busy[wr_addr[w*AW +: AW]] = 1'b0;
        end
      if (issue_valid && !stall && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd6;
    #1;
    checks++;
    if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    checks++;
    if (rd_busy !== '0) begin failures++; $display("FAIL reset_rd_busy got=%b want=00", rd_busy); end
    checks++;
    if (issue_stall !== 1'b0) begin failures++; $display("FAIL reset_issue_stall got=%b want=0", issue_stall); end
    idle();
  endtask

  task automatic test_write_read();
    idle(); set_wr(0, 5'd5, 64'hDEAD); tick();
    idle(); set_rd(0, 5'd5); tick();
    checks++;
    if (rd_data[63:0] !== 64'hDEAD) begin failures++; $display("FAIL write_read_x5 got=%h want=%h", rd_data[63:0], 64'hDEAD); end
    checks++;
    if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL write_read_x5_busy got=%b want=0", rd_busy[0]); end
  endtask

  task automatic test_x0();
    idle(); set_wr(0, 5'd0, 64'h1234); issue_valid = 1'b1; issue_rd = 5'd0; tick();
    idle(); set_rd(0, 5'd0); set_rd(1, 5'd0); issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin failures++; $display("FAIL x0_issue_stall got=%b want=0", issue_stall); end
    tick();
    checks++;
    if (rd_data !== '0) begin failures++; $display("FAIL x0_rd_data got=%h want=0", rd_data); end
    checks++;
    if (rd_busy !== '0) begin failures++; $display("FAIL x0_rd_busy got=%b want=00", rd_busy); end
  endtask

  task automatic test_write_priority();
    idle(); set_wr(0, 5'd7, 64'h11); set_wr(1, 5'd7, 64'h22); tick();
    idle(); set_rd(1, 5'd7); tick();
    checks++;
    if (rd_data[127:64] !== 64'h22) begin failures++; $display("FAIL write_priority_x7 got=%h want=22", rd_data[127:64]); end
  endtask

  task automatic test_scoreboard();
    idle(); issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin failures++; $display("FAIL sb_first_issue_stall got=%b want=0", issue_stall); end
    tick();
    set_rd(0, 5'd9);
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin failures++; $display("FAIL sb_reissue_stall got=%b want=1", issue_stall); end
    tick();
    checks++;
    if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sb_busy_x9 got=%b want=1", rd_busy[0]); end
    idle(); set_rd(0, 5'd9); set_wr(1, 5'd9, 64'h99); tick();
    checks++;
    if (rd_busy[0] !== exp_busy[0]) begin failures++; $display("FAIL sb_busy_wb_edge got=%b want=%b", rd_busy[0], exp_busy[0]); end
    idle(); set_rd(0, 5'd9); tick();
    checks++;
    if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sb_busy_after_wb got=%b want=0", rd_busy[0]); end
    checks++;
    if (rd_data[63:0] !== 64'h99) begin failures++; $display("FAIL sb_data_after_wb got=%h want=99", rd_data[63:0]); end
    idle(); issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin failures++; $display("FAIL sb_reissue_after_wb got=%b want=0", issue_stall); end
    tick();
    idle(); set_rd(0, 5'd9); tick();
    checks++;
    if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sb_busy_reissued got=%b want=1", rd_busy[0]); end
    // Issue and writeback of x10 on the same edge: new producer keeps it busy.
    idle(); issue_valid = 1'b1; issue_rd = 5'd10; set_wr(0, 5'd10, 64'hA0); tick();
    idle(); set_rd(1, 5'd10); tick();
    checks++;
    if (rd_busy[1] !== 1'b1) begin failures++; $display("FAIL sb_issue_wb_same_edge got=%b want=1", rd_busy[1]); end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] want;
    idle(); set_wr(0, 5'd3, 64'h77); tick();
    idle(); set_rd(0, 5'd3); set_wr(1, 5'd3, 64'h55); tick();
`ifdef REGFILE_BYPASS_EN
    want = 64'h55;
`else
    want = 64'h77;
`endif
    checks++;
    if (rd_data[63:0] !== want) begin failures++; $display("FAIL bypass_same_edge got=%h want=%h", rd_data[63:0], want); end
    idle(); set_rd(0, 5'd3); tick();
    checks++;
    if (rd_data[63:0] !== 64'h55) begin failures++; $display("FAIL bypass_next_read got=%h want=55", rd_data[63:0]); end
  endtask

  task automatic test_reset_priority();
    idle(); set_wr(0, 5'd4, 64'hAB); tick();
    idle(); reset = 1'b1; set_wr(1, 5'd4, 64'hCD); issue_valid = 1'b1; issue_rd = 5'd4; tick();
    idle(); set_rd(0, 5'd4); tick();
    checks++;
    if (rd_data[63:0] !== 64'h0) begin failures++; $display("FAIL reset_prio_x4_data got=%h want=0", rd_data[63:0]); end
    checks++;
    if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL reset_prio_x4_busy got=%b want=0", rd_busy[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit narrow;
      idle();
      narrow = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NRD; p++)
        set_rd(p, reg_idx_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31)));
      for (int w = 0; w < NWR; w++)
        if ($urandom_range(0, 2) != 0)
          set_wr(w, reg_idx_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                 {$urandom, $urandom});
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd = reg_idx_t'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      #1;
      checks++;
      if (issue_stall !== model_stall()) begin
        failures++;
        $display("FAIL rand_issue_stall cyc=%0d got=%b want=%b", c, issue_stall, model_stall());
      end
      tick();
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== exp_data[p]) begin
          failures++;
          $display("FAIL rand_rd_data cyc=%0d port=%0d got=%h want=%h", c, p, rd_data[p*XLEN +: XLEN], exp_data[p]);
        end
        checks++;
        if (rd_busy[p] !== exp_busy[p]) begin
          failures++;
          $display("FAIL rand_rd_busy cyc=%0d port=%0d got=%b want=%b", c, p, rd_busy[p], exp_busy[p]);
        end
      end
    end
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_x0();
    test_write_priority();
    test_scoreboard();
    test_bypass();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
